// File: rtl/sound_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sound_sequencer
// Description : Collects one-cycle sound requests, arbitrates them by fixed
//               priority (req[3] highest) and plays the granted hard-coded
//               note sequence by driving the oscillator divisor and enable.
//               A higher-priority request preempts a running sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module sound_sequencer #(
    parameter int TICK_DIV = 120000
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic [3:0] req,
    input  logic       mute,
    output logic [7:0] freq,
    output logic       tone_en,
    output logic       busy,
    output logic [1:0] playing_id,
    output logic       done
);

    localparam int                  C_TICK_W    = $clog2(TICK_DIV);
    localparam logic [C_TICK_W-1:0] C_TICK_LAST = C_TICK_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    typedef struct packed {
        logic [7:0] div;
        logic [7:0] dur;
    } note_t;

    // Note ROM: divisor and duration (in ticks) for note idx of sequence id.
    function automatic note_t note_rom(input logic [1:0] id, input logic [1:0] idx);
        note_t n;
        case ({id, idx})
            4'b00_00: n = '{8'd89,  8'd2};
            4'b01_00: n = '{8'd89,  8'd10};
            4'b01_01: n = '{8'd67,  8'd10};
            4'b10_00: n = '{8'd156, 8'd50};
            4'b11_00: n = '{8'd119, 8'd20};
            4'b11_01: n = '{8'd134, 8'd20};
            4'b11_10: n = '{8'd156, 8'd20};
            4'b11_11: n = '{8'd178, 8'd40};
            default:  n = '{8'd0,   8'd1};
        endcase
        return n;
    endfunction

    // Index of the final note of each sequence.
    function automatic logic [1:0] last_idx(input logic [1:0] id);
        case (id)
            2'd1:    return 2'd1;
            2'd3:    return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // Highest set bit of the pending vector (0 when empty; qualify with |p).
    function automatic logic [1:0] top_bit(input logic [3:0] p);
        if (p[3])      return 2'd3;
        else if (p[2]) return 2'd2;
        else if (p[1]) return 2'd1;
        else           return 2'd0;
    endfunction

    state_t              state_q, state_d;
    logic [3:0]          pending_q, pending_d;
    logic [C_TICK_W-1:0] tick_q, tick_d;
    logic [7:0]          dur_cnt_q, dur_cnt_d;
    logic [1:0]          note_q, note_d;
    logic [7:0]          freq_q, freq_d;
    logic                tone_en_q, tone_en_d;
    logic                busy_q, busy_d;
    logic [1:0]          id_q, id_d;
    logic                done_q, done_d;

    logic [1:0]          w_win;
    logic                w_grant;
    logic                w_tick_end;
    note_t               w_load;

    assign w_win      = top_bit(pending_q);
    // In IDLE any pending request wins; while playing only a strictly
    // higher-priority one may preempt.
    assign w_grant    = (|pending_q) && ((state_q == S_IDLE) || (w_win > id_q));
    assign w_tick_end = (tick_q == C_TICK_LAST);
    // The note about to be loaded: note 0 of a new grant, else the next note.
    assign w_load     = note_rom(w_grant ? w_win : id_q,
                                 w_grant ? 2'd0  : note_q + 2'd1);

    // Next-state and registered-output computation for the sequencer.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q | req;
        tick_d    = tick_q;
        dur_cnt_d = dur_cnt_q;
        note_d    = note_q;
        freq_d    = freq_q;
        tone_en_d = tone_en_q;
        busy_d    = busy_q;
        id_d      = id_q;
        done_d    = 1'b0;

        if (mute) begin
            state_d   = S_IDLE;
            pending_d = '0;
            tick_d    = '0;
            dur_cnt_d = '0;
            note_d    = '0;
            freq_d    = '0;
            tone_en_d = 1'b0;
            busy_d    = 1'b0;
        end else if (w_grant) begin
            // A request arriving on the grant cycle re-sets its bit (replay).
            state_d   = S_PLAY;
            pending_d = (pending_q & ~(4'b0001 << w_win)) | req;
            tick_d    = '0;
            dur_cnt_d = w_load.dur;
            note_d    = '0;
            freq_d    = w_load.div;
            tone_en_d = 1'b1;
            busy_d    = 1'b1;
            id_d      = w_win;
        end else begin
            case (state_q)
                S_PLAY: begin
                    tick_d = w_tick_end ? '0 : tick_q + 1'b1;
                    if (w_tick_end) begin
                        dur_cnt_d = dur_cnt_q - 8'd1;
                    end
                    if (w_tick_end && (dur_cnt_q == 8'd1)) begin
                        dur_cnt_d = '0;
                        freq_d    = '0;
                        tone_en_d = 1'b0;
                        if (note_q == last_idx(id_q)) begin
                            state_d = S_IDLE;
                            note_d  = '0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (w_tick_end) begin
                        state_d   = S_PLAY;
                        tick_d    = '0;
                        note_d    = note_q + 2'd1;
                        dur_cnt_d = w_load.dur;
                        freq_d    = w_load.div;
                        tone_en_d = 1'b1;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            tick_q    <= '0;
            dur_cnt_q <= '0;
            note_q    <= '0;
            freq_q    <= '0;
            tone_en_q <= 1'b0;
            busy_q    <= 1'b0;
            id_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            tick_q    <= tick_d;
            dur_cnt_q <= dur_cnt_d;
            note_q    <= note_d;
            freq_q    <= freq_d;
            tone_en_q <= tone_en_d;
            busy_q    <= busy_d;
            id_q      <= id_d;
            done_q    <= done_d;
        end
    end

    assign freq       = freq_q;
    assign tone_en    = tone_en_q;
    assign busy       = busy_q;
    assign playing_id = id_q;
    assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sound_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_sound_sequencer
// Description : Self-checking bench for sound_sequencer. Each sequence is
//               expanded into a per-cycle divisor timeline; the reference
//               model just walks a position through that timeline.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sound_sequencer;

    localparam int TICK_DIV = 4;

    logic       clk  = 1'b0;
    logic       nRst = 1'b0;
    logic [3:0] req  = 4'h0;
    logic       mute = 1'b0;
    logic [7:0] freq;
    logic       tone_en;
    logic       busy;
    logic [1:0] playing_id;
    logic       done;

    always #5 clk = ~clk;

    sound_sequencer #(.TICK_DIV(TICK_DIV)) dut (
        .clk        (clk),
        .nRst       (nRst),
        .req        (req),
        .mute       (mute),
        .freq       (freq),
        .tone_en    (tone_en),
        .busy       (busy),
        .playing_id (playing_id),
        .done       (done)
    );

    int errors = 0;
    int checks = 0;

    // Flattened per-cycle divisor timelines, one slice per sequence.
    logic [7:0] tl [$];
    int         tl_base [4];
    int         tl_len  [4];

    // Reference model state.
    logic [3:0] m_pend = 4'h0;
    logic       m_busy = 1'b0;
    logic [1:0] m_id   = 2'd0;
    int         m_pos  = 0;
    logic       m_done = 1'b0;

    task automatic build_timelines();
        int ncnt [4];
        int ndiv [4][4];
        int ndur [4][4];
        ncnt = '{1, 2, 1, 4};
        ndiv = '{'{89, 0, 0, 0}, '{89, 67, 0, 0}, '{156, 0, 0, 0}, '{119, 134, 156, 178}};
        ndur = '{'{2, 0, 0, 0},  '{10, 10, 0, 0}, '{50, 0, 0, 0},  '{20, 20, 20, 40}};
        for (int id = 0; id < 4; id++) begin
            tl_base[id] = tl.size();
            for (int n = 0; n < ncnt[id]; n++) begin
                if (n > 0) begin
                    for (int g = 0; g < TICK_DIV; g++) tl.push_back(8'd0);
                end
                for (int c = 0; c < ndur[id][n] * TICK_DIV; c++) tl.push_back(8'(ndiv[id][n]));
            end
            tl_len[id] = tl.size() - tl_base[id];
        end
    endtask

    // Advance the model by one clock edge given the inputs seen at that edge.
    task automatic model_step(input logic [3:0] r, input logic mu, input logic rn);
        logic [3:0] np;
        int         win;
        if (!rn) begin
            m_pend = 4'h0; m_busy = 1'b0; m_id = 2'd0; m_pos = 0; m_done = 1'b0;
        end else if (mu) begin
            m_pend = 4'h0; m_busy = 1'b0; m_done = 1'b0;
        end else begin
            win = -1;
            for (int i = 3; i >= 0; i--) if (m_pend[i] && win < 0) win = i;
            np     = m_pend | r;
            m_done = 1'b0;
            if (win >= 0 && (!m_busy || win > int'(m_id))) begin
                m_busy  = 1'b1;
                m_id    = 2'(win);
                m_pos   = 0;
                np[win] = r[win];
            end else if (m_busy) begin
                m_pos++;
                if (m_pos == tl_len[m_id]) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
            m_pend = np;
        end
    endtask

    // Drive one cycle of inputs, then compare all outputs after the edge.
    task automatic step(input logic [3:0] r, input logic mu, input logic rn);
        logic [7:0]  ef;
        logic        et;
        logic [12:0] exp_v;
        logic [12:0] obs_v;
        req  = r;
        mute = mu;
        nRst = rn;
        @(posedge clk);
        #1;
        model_step(r, mu, rn);
        ef    = m_busy ? tl[tl_base[m_id] + m_pos] : 8'd0;
        et    = m_busy && (ef != 8'd0);
        exp_v = {ef, et, m_busy, m_id, m_done};
        obs_v = {freq, tone_en, busy, playing_id, done};
        checks++;
        assert (obs_v === exp_v) else begin
            errors++;
            $error("FAIL outs t=%0t observed freq=%0d tone_en=%b busy=%b id=%0d done=%b expected freq=%0d tone_en=%b busy=%b id=%0d done=%b",
                   $time, freq, tone_en, busy, playing_id, done, ef, et, m_busy, m_id, m_done);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(4'h0, 1'b0, 1'b1);
    endtask

    initial begin
        int mute_left;
        logic [3:0] r;
        logic       mu;
        logic       rn;

        build_timelines();

        // Reset held with all requests asserted; nothing may start afterwards.
        for (int i = 0; i < 3; i++) step(4'hF, 1'b0, 1'b0);
        run(6);

        // Single click, then single good-collision sequence.
        step(4'b0001, 1'b0, 1'b1);
        run(15);
        step(4'b0010, 1'b0, 1'b1);
        run(95);

        // Two simultaneous requests: id2 first, then id1 after one idle cycle.
        step(4'b0110, 1'b0, 1'b1);
        run(300);

        // Preemption of id1 by id3; a later click waits for id3 to finish.
        step(4'b0010, 1'b0, 1'b1);
        run(20);
        step(4'b1000, 1'b0, 1'b1);
        run(6);
        step(4'b0001, 1'b0, 1'b1);
        run(440);

        // Mute mid-note; a click issued while muted must never play.
        step(4'b0100, 1'b0, 1'b1);
        run(30);
        step(4'b0000, 1'b1, 1'b1);
        step(4'b0001, 1'b1, 1'b1);
        step(4'b0000, 1'b1, 1'b1);
        run(20);

        // Reset mid-sequence.
        step(4'b1000, 1'b0, 1'b1);
        run(30);
        step(4'b0000, 1'b0, 1'b0);
        run(10);

        // Randomized traffic: sparse requests, occasional mute bursts/resets.
        mute_left = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 4; b++) r[b] = ($urandom_range(0, 59) == 0);
            if (mute_left == 0 && $urandom_range(0, 299) == 0) mute_left = $urandom_range(1, 5);
            mu = (mute_left != 0);
            if (mute_left != 0) mute_left--;
            rn = ($urandom_range(0, 1499) != 0);
            step(r, mu, rn);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sound_sequencer.md
# sound_sequencer

Sound-event scheduler that sits in front of the tone oscillator and DAC ramp counter. It collects one-cycle sound requests from the game logic (move click, good collision, bad collision, game over) and arbitrates them by fixed priority. For the granted event it plays a hard-coded note sequence by driving the oscillator's 8-bit period divisor and enable, including note durations and inter-note gaps. A higher-priority request preempts a lower-priority sequence that is already playing.

## Interface
- TICK_DIV, 120000, clk cycles per duration tick (10 ms at 12 MHz); must be ≥ 2
- clk  in  1  system clock
- nRst  in  1  synchronous active-low reset (one clock; reset is synchronous and active-low)
- req  in  4  sound requests, one-cycle pulses: [3] game over (highest), [2] bad collision, [1] good collision, [0] move click (lowest)
- mute  in  1  level; silences output and discards all requests
- freq  out  8  period divisor to oscillator; 0 when silent
- tone_en  out  1  oscillator enable; 1 only while a note sounds
- busy  out  1  sequence in progress (PLAY or GAP)
- playing_id  out  2  index of the sequence in progress; holds last value when idle
- done  out  1  one-cycle pulse when a sequence completes normally

## Operation
- Note ROM (divisor, duration in ticks):
  - id0: (89, 2)
  - id1: (89, 10), (67, 10)
  - id2: (156, 50)
  - id3: (119, 20), (134, 20), (156, 20), (178, 40)
- pending[3:0] register: bit i set on any cycle req[i]=1 and mute=0. Bit i is cleared on the edge where sequence i is granted. If set and clear occur in the same cycle, set wins (event replays later). A held-high req retriggers repeatedly; this is the requester's responsibility.
- Arbitration: highest set pending bit wins.
- States:
  - IDLE: if any pending bit is set, grant the winner and go to PLAY with note 0. Otherwise stay.
  - PLAY: drives freq = note divisor, tone_en = 1. The note lasts duration × TICK_DIV cycles. At the final cycle, go to GAP if more notes remain. Otherwise go to IDLE and pulse done.
  - GAP: drives freq = 0, tone_en = 0 for exactly TICK_DIV cycles, then goes to PLAY with the next note.
- Preemption: in PLAY or GAP, if pending holds a bit of strictly higher priority than playing_id, the next edge grants it. The new sequence starts PLAY at note 0 with fresh counters. The aborted sequence produces no done and is not re-queued. Equal or lower priority requests stay pending until IDLE.
- Counters:
  - Tick counter: $clog2(TICK_DIV) bits, cleared at every note/gap start.
  - Tick countdown: 8 bits, loaded with the duration.
  - Note index: 2 bits.
  - No wrap-around is permitted; all counters reload on state entry.
- mute=1:
  - Next edge: state = IDLE, pending cleared, freq = 0, tone_en = 0, busy = 0.
  - No done pulse is issued.
  - Requests are ignored while mute is high.
  - playing_id holds.

## Timing
- All outputs are registered; there is no combinational path from req or mute to any output.
- Reset (nRst=0 at an edge) values: state IDLE, pending 0, freq 0, tone_en 0, busy 0, playing_id 0, done 0, all counters 0. Reset mid-sequence aborts it without a done pulse.
- Request latency:
  - req pulse in cycle t sets pending at edge t+1.
  - Grant occurs at edge t+2, when freq, tone_en, busy and playing_id become valid. First note output therefore appears 2 cycles after the request.
- Preemption latency: higher-priority req in cycle t → new freq at edge t+2.
- Sequence completion:
  - Last PLAY cycle → next edge: tone_en = 0, freq = 0, busy = 0, done = 1 for one cycle.
  - The next pending sequence is granted one edge later. There is exactly one IDLE cycle between back-to-back sequences.
- Total cycles for sequence id1: (10 + 1 + 10) × TICK_DIV.

## Test plan
Bench uses TICK_DIV = 4.
1. Reset: hold nRst=0 for 3 cycles with req=4'hF → after release, all outputs are 0 and no sequence starts until a new req arrives.
2. req=4'b0001 at cycle 0:
   - Cycles 2–9: freq=89, tone_en=1, busy=1, playing_id=0.
   - Cycle 10: done=1, busy=0, freq=0.
   - Cycle 11: done=0.
3. req=4'b0010 at cycle 0:
   - freq=89 for cycles 2–41.
   - freq=0, tone_en=0 for cycles 42–45.
   - freq=67 for cycles 46–85.
   - done=1 at cycle 86.
4. req=4'b0110 in one cycle:
   - id2 plays first (freq=156, 200 cycles) and pulses done.
   - One idle cycle follows.
   - id1 starts (freq=89), with playing_id=1.
5. Preemption: id1 is playing; req[3] is pulsed in cycle t → freq=119 and playing_id=3 at edge t+2, with no done pulse for id1. A later req[0] during id3 waits until after id3's done.
6. Mute and reset mid-note:
   - mute=1 during id2 → next edge: tone_en=0, busy=0, no done. A req[0] issued while muted never plays.
   - nRst=0 during id3 → next edge: all outputs at reset values.
